// File: rtl/l2_bus_arbiter_pkg.sv
// Shared types for the L2 processor-side bus arbiter.
package l2_bus_arbiter_pkg;

  localparam int unsigned DataWidth   = 32;
  localparam int unsigned ByteEnWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    StIdle,
    StGrantI,
    StGrantD,
    StFlushIssue,
    StFlushWait,
    StClearIssue,
    StClearWait
  } arb_state_t;

  typedef enum logic {
    GntI,
    GntD
  } grant_t;

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// Generic request/busy memory bus shared by the L1 caches and the L2 proc side.
interface generic_bus_if
  import l2_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth-1:0]   rdata;
  logic                   ren;
  logic                   wen;
  logic                   busy;
  logic [ByteEnWidth-1:0] byte_en;

  // Memory side of a bus: receives the request, returns data and busy.
  modport generic_bus (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy
  );

  // Requester side of a bus: drives the request, sees data and busy.
  modport cpu (
    output addr, ren, wen, wdata, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter sharing the L2 proc-side bus between the L1 I- and D-cache,
// with L2 flush/clear sequenced so they never overlap a live transaction.
module l2_bus_arbiter
  import l2_bus_arbiter_pkg::*;
#(
  parameter bit          DCACHE_FIRST = 1'b1,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  generic_bus_if.generic_bus     icache_bus_if,
  generic_bus_if.generic_bus     dcache_bus_if,
  generic_bus_if.cpu             l2_bus_if,
  input  logic                   flush_req,
  input  logic                   clear_req,
  output logic                   flush_done,
  output logic                   clear_done,
  output logic                   l2_flush,
  output logic                   l2_clear,
  input  logic                   l2_flush_done,
  input  logic                   l2_clear_done
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;

  logic i_req, d_req, maint_req;

  // The I-cache only reads; its wen is deliberately ignored.
  assign i_req     = icache_bus_if.ren;
  assign d_req     = dcache_bus_if.ren | dcache_bus_if.wen;
  assign maint_req = flush_req | clear_req;

  logic unused_icache_wen;
  assign unused_icache_wen = icache_bus_if.wen;

  // Next-state, bus muxing and maintenance pulses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    l2_bus_if.addr    = ADDR_WIDTH'(0);
    l2_bus_if.wdata   = '0;
    l2_bus_if.ren     = 1'b0;
    l2_bus_if.wen     = 1'b0;
    l2_bus_if.byte_en = '0;

    icache_bus_if.busy  = 1'b1;
    icache_bus_if.rdata = '0;
    dcache_bus_if.busy  = 1'b1;
    dcache_bus_if.rdata = '0;

    l2_flush   = 1'b0;
    l2_clear   = 1'b0;
    flush_done = 1'b0;
    clear_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StFlushIssue;
        end else if (clear_req) begin
          state_d = StClearIssue;
        end else if (i_req && d_req) begin
          state_d = (last_grant_q == GntI) ? StGrantD : StGrantI;
        end else if (d_req) begin
          state_d = StGrantD;
        end else if (i_req) begin
          state_d = StGrantI;
        end
      end

      StGrantI: begin
        l2_bus_if.addr      = icache_bus_if.addr;
        l2_bus_if.wdata     = icache_bus_if.wdata;
        l2_bus_if.ren       = icache_bus_if.ren;
        l2_bus_if.byte_en   = icache_bus_if.byte_en;
        icache_bus_if.rdata = l2_bus_if.rdata;
        icache_bus_if.busy  = l2_bus_if.busy;
        if (!l2_bus_if.busy) begin
          last_grant_d = GntI;
          // Hand straight over to a waiting D-cache unless maintenance is queued.
          state_d = (d_req && !maint_req) ? StGrantD : StIdle;
        end
      end

      StGrantD: begin
        l2_bus_if.addr      = dcache_bus_if.addr;
        l2_bus_if.wdata     = dcache_bus_if.wdata;
        l2_bus_if.ren       = dcache_bus_if.ren;
        l2_bus_if.wen       = dcache_bus_if.wen;
        l2_bus_if.byte_en   = dcache_bus_if.byte_en;
        dcache_bus_if.rdata = l2_bus_if.rdata;
        dcache_bus_if.busy  = l2_bus_if.busy;
        if (!l2_bus_if.busy) begin
          last_grant_d = GntD;
          state_d = (i_req && !maint_req) ? StGrantI : StIdle;
        end
      end

      StFlushIssue: begin
        l2_flush = 1'b1;
        state_d  = StFlushWait;
      end

      StFlushWait: begin
        if (l2_flush_done) begin
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end

      StClearIssue: begin
        l2_clear = 1'b1;
        state_d  = StClearWait;
      end

      StClearWait: begin
        if (l2_clear_done) begin
          clear_done = 1'b1;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and round-robin history; reset abandons any live transaction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      last_grant_q <= DCACHE_FIRST ? GntI : GntD;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // An owner must hold its request until it has seen busy=0.
  a_icache_holds_req: assert property (@(posedge CLK) disable iff (RST)
    (state_q == StGrantI) |-> icache_bus_if.ren);
  a_dcache_holds_req: assert property (@(posedge CLK) disable iff (RST)
    (state_q == StGrantD) |-> (dcache_bus_if.ren || dcache_bus_if.wen));

endmodule
